// File: rtl/sdram_mport_ctrl.sv
// sdram_mport_ctrl: multi-channel SDRAM request front-end.
// Per-channel write/read FIFOs feed a single-command arbiter onto the
// SDRAM local bus; read returns are tagged with their channel through
// an in-order tag FIFO.
// Build option: define SDRAM_MPORT_FIXPRIO_EN for fixed priority
// (lowest eligible channel wins); otherwise round-robin arbitration.
`ifndef SDRAM_DATA_NBIT
`define SDRAM_DATA_NBIT 16
`endif

module sdram_mport_ctrl #(
  parameter int P_NCH       = 2,
  parameter int P_ADDR_NBIT = 16,
  parameter int P_DATA_NBIT = 16,
  parameter int P_FIFO_AW   = 3,
  parameter int P_MAX_OUTST = 4,
  parameter int CH_NBIT     = (P_NCH > 1) ? $clog2(P_NCH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [P_NCH-1:0]              wr_req,
  input  logic [P_NCH*P_ADDR_NBIT-1:0]  wr_addr,
  input  logic [P_NCH*P_DATA_NBIT-1:0]  wr_data,
  output logic [P_NCH-1:0]              wr_full,
  output logic [P_NCH-1:0]              wr_idle,
  input  logic [P_NCH-1:0]              rd_req,
  input  logic [P_NCH*P_ADDR_NBIT-1:0]  rd_addr,
  output logic [P_NCH-1:0]              rd_full,
  output logic [P_DATA_NBIT-1:0]        rd_data,
  output logic                          rd_valid,
  output logic [CH_NBIT-1:0]            rd_ch,
  input  logic                          mem_initdone,
  output logic [P_ADDR_NBIT-1:0]        mem_addr,
  output logic                          mem_write,
  output logic                          mem_read,
  output logic [`SDRAM_DATA_NBIT-1:0]   mem_wdata,
  input  logic                          mem_wait,
  input  logic [`SDRAM_DATA_NBIT-1:0]   mem_rdata,
  input  logic                          mem_rdv
);

  localparam int SD_W   = `SDRAM_DATA_NBIT;
  localparam int DEPTH  = 1 << P_FIFO_AW;
  localparam int TAG_AW = (P_MAX_OUTST > 1) ? $clog2(P_MAX_OUTST) : 1;
  localparam int TAG_CW = $clog2(P_MAX_OUTST + 1);
  localparam logic [P_FIFO_AW:0] CNT_FULL = {1'b1, {P_FIFO_AW{1'b0}}};
  localparam logic [TAG_CW-1:0]  TAG_FULL = TAG_CW'(P_MAX_OUTST);
  localparam logic [TAG_AW-1:0]  TAG_LAST = TAG_AW'(P_MAX_OUTST - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CMD} state_t;

  // Write data is placed in the upper bits of the wider memory word.
  function automatic logic [SD_W-1:0] left_justify(input logic [P_DATA_NBIT-1:0] d);
    logic [SD_W-1:0] r;
    r = '0;
    r[SD_W-1 -: P_DATA_NBIT] = d;
    return r;
  endfunction

  // Per-channel FIFO storage (data only, never reset).
  logic [P_ADDR_NBIT-1:0] wf_addr_q [P_NCH][DEPTH];
  logic [P_DATA_NBIT-1:0] wf_data_q [P_NCH][DEPTH];
  logic [P_ADDR_NBIT-1:0] rf_addr_q [P_NCH][DEPTH];
  logic [P_FIFO_AW-1:0]   wf_wp_q [P_NCH];
  logic [P_FIFO_AW-1:0]   wf_rp_q [P_NCH];
  logic [P_FIFO_AW-1:0]   rf_wp_q [P_NCH];
  logic [P_FIFO_AW-1:0]   rf_rp_q [P_NCH];
  logic [P_FIFO_AW:0]     wf_cnt_q [P_NCH];
  logic [P_FIFO_AW:0]     rf_cnt_q [P_NCH];

  // Tag FIFO: channel ids of reads accepted by memory, in issue order.
  logic [CH_NBIT-1:0] tag_q [P_MAX_OUTST];
  logic [TAG_AW-1:0]  tag_wp_q, tag_rp_q;
  logic [TAG_CW-1:0]  tag_cnt_q;

  state_t                 state_q;
  logic                   mem_write_q, mem_read_q;
  logic [P_ADDR_NBIT-1:0] mem_addr_q;
  logic [SD_W-1:0]        mem_wdata_q;
  logic [CH_NBIT-1:0]     cmd_ch_q;
  logic                   rd_valid_q;
  logic [P_DATA_NBIT-1:0] rd_data_q;
  logic [CH_NBIT-1:0]     rd_ch_q;
`ifdef SDRAM_MPORT_FIXPRIO_EN
`else
  logic [CH_NBIT-1:0]     rr_q;
`endif

  logic [P_NCH-1:0] wf_ne, rf_ne, wf_fl, rf_fl, wf_push, rf_push, wf_pop, rf_pop, elig;
  logic             tag_full, tag_ne, tag_push, tag_pop;
  logic             grant_vld, grant_go, sel_is_wr;
  logic [CH_NBIT-1:0] grant_ch;
  logic [P_ADDR_NBIT-1:0] sel_addr;
  logic [P_DATA_NBIT-1:0] sel_wdata;

  assign tag_full = (tag_cnt_q == TAG_FULL);
  assign tag_ne   = (tag_cnt_q != '0);
  assign tag_push = (state_q == S_CMD) && mem_read_q && !mem_wait;
  assign tag_pop  = mem_rdv && tag_ne;
  assign grant_go = (state_q == S_IDLE) && mem_initdone && grant_vld;

  // Per-channel status, push acceptance and arbitration eligibility.
  always_comb begin
    for (int c = 0; c < P_NCH; c++) begin
      wf_ne[c]   = (wf_cnt_q[c] != '0);
      rf_ne[c]   = (rf_cnt_q[c] != '0);
      wf_fl[c]   = (wf_cnt_q[c] == CNT_FULL);
      rf_fl[c]   = (rf_cnt_q[c] == CNT_FULL);
      wf_push[c] = wr_req[c] && !wf_fl[c];
      rf_push[c] = rd_req[c] && !rf_fl[c];
      elig[c]    = wf_ne[c] || (rf_ne[c] && !tag_full);
      wf_pop[c]  = grant_go && (grant_ch == CH_NBIT'(c)) && wf_ne[c];
      rf_pop[c]  = grant_go && (grant_ch == CH_NBIT'(c)) && !wf_ne[c];
      wr_idle[c] = !wf_ne[c] &&
                   !((state_q == S_CMD) && mem_write_q && (cmd_ch_q == CH_NBIT'(c)));
    end
  end

  assign wr_full = wf_fl;
  assign rd_full = rf_fl;

`ifdef SDRAM_MPORT_FIXPRIO_EN
  // Fixed priority: lowest-numbered eligible channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int c = P_NCH - 1; c >= 0; c--) begin
      if (elig[c]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_NBIT'(c);
      end
    end
  end
`else
  // Round-robin: first eligible channel at or above rr_q, else wrap to lowest.
  logic               hi_found;
  logic [CH_NBIT-1:0] hi_ch, lo_ch;
  always_comb begin
    grant_vld = 1'b0;
    hi_found  = 1'b0;
    hi_ch     = '0;
    lo_ch     = '0;
    for (int c = P_NCH - 1; c >= 0; c--) begin
      if (elig[c]) begin
        grant_vld = 1'b1;
        lo_ch     = CH_NBIT'(c);
        if (CH_NBIT'(c) >= rr_q) begin
          hi_found = 1'b1;
          hi_ch    = CH_NBIT'(c);
        end
      end
    end
    grant_ch = hi_found ? hi_ch : lo_ch;
  end
`endif

  // Head-of-queue command of the granted channel; a pending write beats a read.
  always_comb begin
    sel_is_wr = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int c = 0; c < P_NCH; c++) begin
      if (grant_ch == CH_NBIT'(c)) begin
        sel_is_wr = wf_ne[c];
        sel_addr  = wf_ne[c] ? wf_addr_q[c][wf_rp_q[c]] : rf_addr_q[c][rf_rp_q[c]];
        sel_wdata = wf_data_q[c][wf_rp_q[c]];
      end
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk) begin
    for (int c = 0; c < P_NCH; c++) begin
      if (wf_push[c]) begin
        wf_addr_q[c][wf_wp_q[c]] <= wr_addr[c*P_ADDR_NBIT +: P_ADDR_NBIT];
        wf_data_q[c][wf_wp_q[c]] <= wr_data[c*P_DATA_NBIT +: P_DATA_NBIT];
      end
      if (rf_push[c]) begin
        rf_addr_q[c][rf_wp_q[c]] <= rd_addr[c*P_ADDR_NBIT +: P_ADDR_NBIT];
      end
    end
    if (tag_push) tag_q[tag_wp_q] <= cmd_ch_q;
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < P_NCH; c++) begin
        wf_wp_q[c] <= '0;  wf_rp_q[c] <= '0;  wf_cnt_q[c] <= '0;
        rf_wp_q[c] <= '0;  rf_rp_q[c] <= '0;  rf_cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < P_NCH; c++) begin
        if (wf_push[c]) wf_wp_q[c] <= wf_wp_q[c] + 1'b1;
        if (wf_pop[c])  wf_rp_q[c] <= wf_rp_q[c] + 1'b1;
        if (rf_push[c]) rf_wp_q[c] <= rf_wp_q[c] + 1'b1;
        if (rf_pop[c])  rf_rp_q[c] <= rf_rp_q[c] + 1'b1;
        case ({wf_push[c], wf_pop[c]})
          2'b10:   wf_cnt_q[c] <= wf_cnt_q[c] + 1'b1;
          2'b01:   wf_cnt_q[c] <= wf_cnt_q[c] - 1'b1;
          default: wf_cnt_q[c] <= wf_cnt_q[c];
        endcase
        case ({rf_push[c], rf_pop[c]})
          2'b10:   rf_cnt_q[c] <= rf_cnt_q[c] + 1'b1;
          2'b01:   rf_cnt_q[c] <= rf_cnt_q[c] - 1'b1;
          default: rf_cnt_q[c] <= rf_cnt_q[c];
        endcase
      end
    end
  end

  // Tag FIFO pointers and count; depth need not be a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_wp_q  <= '0;
      tag_rp_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      if (tag_push) tag_wp_q <= (tag_wp_q == TAG_LAST) ? '0 : tag_wp_q + 1'b1;
      if (tag_pop)  tag_rp_q <= (tag_rp_q == TAG_LAST) ? '0 : tag_rp_q + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
        2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
        default: tag_cnt_q <= tag_cnt_q;
      endcase
    end
  end

  // Read return: one cycle after mem_rdv, tagged with the popped channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ch_q    <= '0;
    end else begin
      rd_valid_q <= tag_pop;
      if (tag_pop) begin
        rd_data_q <= mem_rdata[SD_W-1 -: P_DATA_NBIT];
        rd_ch_q   <= tag_q[tag_rp_q];
      end
    end
  end

  // Arbiter FSM with registered command outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cmd_ch_q    <= '0;
`ifndef SDRAM_MPORT_FIXPRIO_EN
      rr_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_INIT: begin
          if (mem_initdone) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (!mem_initdone) begin
            state_q <= S_INIT;
          end else if (grant_vld) begin
            state_q    <= S_CMD;
            cmd_ch_q   <= grant_ch;
            mem_addr_q <= sel_addr;
            if (sel_is_wr) begin
              mem_write_q <= 1'b1;
              mem_wdata_q <= left_justify(sel_wdata);
            end else begin
              mem_read_q  <= 1'b1;
            end
`ifndef SDRAM_MPORT_FIXPRIO_EN
            rr_q <= (grant_ch == CH_NBIT'(P_NCH - 1)) ? '0 : grant_ch + 1'b1;
`endif
          end
        end
        S_CMD: begin
          if (!mem_wait) begin
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            state_q     <= mem_initdone ? S_IDLE : S_INIT;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_ch     = rd_ch_q;

endmodule

// File: tb/tb_sdram_mport_ctrl.sv
// Directed testbench for sdram_mport_ctrl (default parameters).
`ifndef SDRAM_DATA_NBIT
`define SDRAM_DATA_NBIT 16
`endif

module tb_sdram_mport_ctrl;
  localparam int NCH = 2;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int SDW = `SDRAM_DATA_NBIT;
  localparam int CHW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [NCH-1:0]     wr_req, rd_req, wr_full, wr_idle, rd_full;
  logic [NCH*AW-1:0]  wr_addr, rd_addr;
  logic [NCH*DW-1:0]  wr_data;
  logic [DW-1:0]      rd_data;
  logic               rd_valid;
  logic [CHW-1:0]     rd_ch;
  logic               mem_initdone, mem_write, mem_read, mem_wait, mem_rdv;
  logic [AW-1:0]      mem_addr;
  logic [SDW-1:0]     mem_wdata, mem_rdata;

  logic               rdv_man;
  logic               rdv_auto = 1'b0;
  logic               auto_en;
  logic [SDW-1:0]     rdata_man;
  logic [SDW-1:0]     rdata_auto = '0;

  assign mem_rdv   = rdv_man | rdv_auto;
  assign mem_rdata = rdv_auto ? rdata_auto : rdata_man;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] log_addr [$];
  logic          log_we   [$];
  logic [DW-1:0] log_data [$];
  logic [CHW-1:0] rv_ch   [$];
  logic [DW-1:0]  rv_data [$];

  sdram_mport_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_full(wr_full), .wr_idle(wr_idle),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_full(rd_full),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ch(rd_ch),
    .mem_initdone(mem_initdone), .mem_addr(mem_addr),
    .mem_write(mem_write), .mem_read(mem_read), .mem_wdata(mem_wdata),
    .mem_wait(mem_wait), .mem_rdata(mem_rdata), .mem_rdv(mem_rdv)
  );

  function automatic logic [SDW-1:0] mk(input logic [DW-1:0] d);
    logic [SDW-1:0] r;
    r = '0;
    r[SDW-1 -: DW] = d;
    return r;
  endfunction

  // Log every command the memory accepts.
  always @(posedge clk) begin
    if (rst_n && (mem_write || mem_read) && !mem_wait) begin
      log_addr.push_back(mem_addr);
      log_we.push_back(mem_write);
      log_data.push_back(mem_wdata[SDW-1 -: DW]);
    end
  end

  // Auto memory: answers each accepted read one cycle later with addr^A5A5.
  always @(posedge clk) begin
    rdv_auto   <= auto_en && rst_n && mem_read && !mem_wait;
    rdata_auto <= mk(mem_addr ^ 16'hA5A5);
  end

  // Log returned read data.
  always @(posedge clk) begin
    if (rd_valid) begin
      rv_ch.push_back(rd_ch);
      rv_data.push_back(rd_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_we.delete(); log_data.delete();
    rv_ch.delete(); rv_data.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_req = '0; rd_req = '0; mem_wait = 1'b0;
    rdv_man = 1'b0; auto_en = 1'b0;
    tick(); tick();
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic push_wr(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req = '0;
    wr_req[ch] = 1'b1;
    wr_addr[ch*AW +: AW] = a;
    wr_data[ch*DW +: DW] = d;
    tick();
    wr_req = '0;
  endtask

  task automatic push_rd(input int ch, input logic [AW-1:0] a);
    rd_req = '0;
    rd_req[ch] = 1'b1;
    rd_addr[ch*AW +: AW] = a;
    tick();
    rd_req = '0;
  endtask

  task automatic test_reset();
    mem_initdone = 1'b0;
    do_reset();
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    n_checks++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
    n_checks++; if (rd_ch !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ch: got %h want 0", rd_ch); end
    n_checks++; if (wr_full !== 2'b00) begin n_fail++; $display("FAIL reset_wr_full: got %b want 00", wr_full); end
    n_checks++; if (rd_full !== 2'b00) begin n_fail++; $display("FAIL reset_rd_full: got %b want 00", rd_full); end
    n_checks++; if (wr_idle !== 2'b11) begin n_fail++; $display("FAIL reset_wr_idle: got %b want 11", wr_idle); end
  endtask

  task automatic test_init_gating();
    logic [AW-1:0] ea [3];
    logic [DW-1:0] ed [3];
    ea = '{16'h0100, 16'h0101, 16'h0102};
    ed = '{16'h1111, 16'h2222, 16'h3333};
    push_wr(0, ea[0], ed[0]);
    n_checks++; if (wr_idle[0] !== 1'b0) begin n_fail++; $display("FAIL init_wr_idle_drop: got %b want 0", wr_idle[0]); end
    push_wr(0, ea[1], ed[1]);
    push_wr(0, ea[2], ed[2]);
    for (int k = 0; k < 5; k++) tick();
    n_checks++; if (log_addr.size() != 0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL init_gated: got %0d cmds strobe %b want 0 cmds strobe 0", log_addr.size(), mem_write); end
    mem_initdone = 1'b1;
    for (int k = 0; k < 40 && log_addr.size() < 3; k++) tick();
    n_checks++; if (log_addr.size() != 3) begin n_fail++; $display("FAIL init_cmd_count: got %0d want 3", log_addr.size()); end
    n_checks++; if (wr_idle[0] !== 1'b1) begin n_fail++; $display("FAIL init_wr_idle_rise: got %b want 1", wr_idle[0]); end
    for (int i = 0; i < 3; i++) begin
      if (i < log_addr.size()) begin
        n_checks++;
        if (log_addr[i] !== ea[i] || log_data[i] !== ed[i] || log_we[i] !== 1'b1) begin
          n_fail++; $display("FAIL init_order[%0d]: got addr %h data %h we %b want addr %h data %h we 1", i, log_addr[i], log_data[i], log_we[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_latency();
    clear_logs();
    push_wr(1, 16'h0800, 16'hBEEF);
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL lat_n1: got %b want 0", mem_write); end
    tick();
    n_checks++; if (mem_write !== 1'b1 || mem_addr !== 16'h0800 || mem_wdata !== mk(16'hBEEF)) begin
      n_fail++; $display("FAIL lat_n2: got we %b addr %h data %h want 1 0800 BEEF", mem_write, mem_addr, mem_wdata); end
    n_checks++; if (wr_idle[1] !== 1'b0) begin n_fail++; $display("FAIL lat_idle_pend: got %b want 0", wr_idle[1]); end
    tick();
    n_checks++; if (mem_write !== 1'b0 || wr_idle[1] !== 1'b1) begin n_fail++; $display("FAIL lat_drop: got strobe %b idle %b want 0 1", mem_write, wr_idle[1]); end
  endtask

  task automatic test_overflow();
    mem_initdone = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push_wr(1, 16'(16'h0200 + i), 16'(16'h5000 + i));
      if (i == 6) begin
        n_checks++; if (wr_full[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_not_full7: got %b want 0", wr_full[1]); end
      end
      if (i == 7) begin
        n_checks++; if (wr_full !== 2'b10) begin n_fail++; $display("FAIL ovf_full8: got %b want 10", wr_full); end
      end
    end
    mem_initdone = 1'b1;
    for (int k = 0; k < 60 && log_addr.size() < 8; k++) tick();
    for (int k = 0; k < 10; k++) tick();
    n_checks++; if (log_addr.size() != 8) begin n_fail++; $display("FAIL ovf_count: got %0d want 8", log_addr.size()); end
    if (log_addr.size() >= 8) begin
      n_checks++; if (log_addr[7] !== 16'h0207 || log_data[7] !== 16'h5007) begin
        n_fail++; $display("FAIL ovf_last: got %h/%h want 0207/5007", log_addr[7], log_data[7]); end
    end
    n_checks++; if (wr_full[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: got %b want 0", wr_full[1]); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] ex [8];
`ifdef SDRAM_MPORT_FIXPRIO_EN
    ex = '{16'h0300, 16'h0301, 16'h0302, 16'h0303, 16'h0400, 16'h0401, 16'h0402, 16'h0403};
`else
    ex = '{16'h0300, 16'h0400, 16'h0301, 16'h0401, 16'h0302, 16'h0402, 16'h0303, 16'h0403};
`endif
    mem_initdone = 1'b0;
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = {16'(16'h0400 + i), 16'(16'h0300 + i)};
      rd_req = 2'b11;
      tick();
      rd_req = 2'b00;
    end
    mem_initdone = 1'b1;
    for (int k = 0; k < 100 && (log_addr.size() < 8 || rv_data.size() < 8); k++) tick();
    n_checks++; if (log_addr.size() != 8) begin n_fail++; $display("FAIL rr_count: got %0d want 8", log_addr.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < log_addr.size()) begin
        n_checks++; if (log_addr[i] !== ex[i] || log_we[i] !== 1'b0) begin
          n_fail++; $display("FAIL rr_order[%0d]: got %h we %b want %h we 0", i, log_addr[i], log_we[i], ex[i]); end
      end
      if (i < rv_data.size()) begin
        n_checks++; if (rv_data[i] !== (ex[i] ^ 16'hA5A5) || rv_ch[i] !== ex[i][10]) begin
          n_fail++; $display("FAIL rr_ret[%0d]: got ch %0d data %h want ch %0d data %h", i, rv_ch[i], rv_data[i], ex[i][10], ex[i] ^ 16'hA5A5); end
      end
    end
    n_checks++; if (rv_data.size() != 8) begin n_fail++; $display("FAIL rr_ret_count: got %0d want 8", rv_data.size()); end
    auto_en = 1'b0;
  endtask

  task automatic test_tagging();
    mem_initdone = 1'b1;
    do_reset();
    push_rd(1, 16'h0010);
    push_rd(0, 16'h0020);
    for (int k = 0; k < 20 && log_addr.size() < 2; k++) tick();
    n_checks++; if (log_addr.size() != 2) begin n_fail++; $display("FAIL tag_cmds: got %0d want 2", log_addr.size()); end
    if (log_addr.size() == 2) begin
      n_checks++; if (log_addr[0] !== 16'h0010 || log_addr[1] !== 16'h0020 || log_we[0] !== 1'b0) begin
        n_fail++; $display("FAIL tag_issue: got %h %h we %b want 0010 0020 we 0", log_addr[0], log_addr[1], log_we[0]); end
    end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL tag_pre_valid: got %b want 0", rd_valid); end
    rdv_man = 1'b1; rdata_man = mk(16'hAAAA);
    tick();
    n_checks++; if (rd_valid !== 1'b1 || rd_ch !== 1'b1 || rd_data !== 16'hAAAA) begin
      n_fail++; $display("FAIL tag_first: got v %b ch %0d data %h want v 1 ch 1 data AAAA", rd_valid, rd_ch, rd_data); end
    rdata_man = mk(16'hBBBB);
    tick();
    n_checks++; if (rd_valid !== 1'b1 || rd_ch !== 1'b0 || rd_data !== 16'hBBBB) begin
      n_fail++; $display("FAIL tag_second: got v %b ch %0d data %h want v 1 ch 0 data BBBB", rd_valid, rd_ch, rd_data); end
    rdata_man = mk(16'hCCCC);
    tick();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL tag_empty_rdv: got %b want 0", rd_valid); end
    rdv_man = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    mem_initdone = 1'b1;
    do_reset();
    mem_wait = 1'b1;
    push_wr(0, 16'h0555, 16'h1234);
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (mem_write !== 1'b1 || mem_addr !== 16'h0555 || mem_wdata !== mk(16'h1234)) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got we %b addr %h data %h want 1 0555 1234", i, mem_write, mem_addr, mem_wdata); end
      tick();
    end
    mem_wait = 1'b0;
    tick();
    n_checks++; if (mem_write !== 1'b0 || log_addr.size() != 1) begin
      n_fail++; $display("FAIL bp_release: got strobe %b cmds %0d want 0 1", mem_write, log_addr.size()); end
  endtask

  task automatic test_outstanding();
    mem_initdone = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) push_rd(0, 16'(16'h0600 + i));
    for (int k = 0; k < 30; k++) tick();
    n_checks++; if (log_addr.size() != 4 || mem_read !== 1'b0) begin
      n_fail++; $display("FAIL outst_limit: got %0d cmds strobe %b want 4 cmds strobe 0", log_addr.size(), mem_read); end
    rdv_man = 1'b1; rdata_man = mk(16'h0F0F);
    tick();
    rdv_man = 1'b0;
    for (int k = 0; k < 20 && log_addr.size() < 5; k++) tick();
    n_checks++; if (log_addr.size() != 5) begin n_fail++; $display("FAIL outst_release: got %0d want 5", log_addr.size()); end
    if (log_addr.size() == 5) begin
      n_checks++; if (log_addr[4] !== 16'h0604) begin n_fail++; $display("FAIL outst_fifth: got %h want 0604", log_addr[4]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    mem_initdone = 1'b1;
    do_reset();
    push_rd(0, 16'h0700);
    push_rd(0, 16'h0701);
    push_rd(0, 16'h0702);
    for (int k = 0; k < 20 && log_addr.size() < 2; k++) tick();
    mem_wait = 1'b1;
    tick();
    n_checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0702) begin
      n_fail++; $display("FAIL mid_in_cmd: got rd %b addr %h want 1 0702", mem_read, mem_addr); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL mid_strobe_drop: got rd %b wr %b want 0 0", mem_read, mem_write); end
    rst_n = 1'b1; mem_wait = 1'b0;
    rdv_man = 1'b1; rdata_man = mk(16'hDEAD);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rdv_man = 1'b0;
      tick();
      n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_rdv[%0d]: got %b want 0", i, rd_valid); end
    end
    for (int k = 0; k < 5; k++) tick();
    n_checks++; if (log_addr.size() != 2 || mem_read !== 1'b0) begin
      n_fail++; $display("FAIL mid_discard: got %0d cmds strobe %b want 2 cmds strobe 0", log_addr.size(), mem_read); end
  endtask

  initial begin
    rst_n = 1'b0; wr_req = '0; rd_req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    mem_initdone = 1'b0; mem_wait = 1'b0; rdv_man = 1'b0; auto_en = 1'b0; rdata_man = '0;
    test_reset();
    test_init_gating();
    test_latency();
    test_overflow();
    test_round_robin();
    test_tagging();
    test_backpressure();
    test_outstanding();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
